// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : fnd_scan_controller
//  Description : Time-multiplexed scan sequencer for a 4-digit FND display.
//                It cycles the digit-select decoder through digits 0..3. Each
//                digit is held for CLK_DIV clocks. It also feeds the matching
//                nibble to the BCD-to-FND font decoder.
//                - Display data is snapshotted once per frame, so a frame
//                  never mixes old and new digits (no tearing).
//                - o_en is held low for the first BLANK_CYC clocks of every
//                  slot. This suppresses ghosting while the digit driver
//                  switches.
//                - Optional leading-zero blanking is applied to the
//                  snapshotted value.
//  Ports       : i_clk          system clock, rising edge
//                i_reset        synchronous active-high reset
//                i_en           scan enable (0 = display idle/off)
//                i_value[15:0]  four nibbles, [3:0] = digit 0
//                i_dp[3:0]      decimal point per digit
//                i_lzb          leading-zero blanking enable (live)
//                o_digitSelect  current digit index
//                o_value        nibble of the current digit
//                o_dp           decimal point of the current digit, gated by o_en
//                o_en           enable to both decoders
//                o_frame        one-cycle pulse coincident with the 3->0 wrap
//  Revision    : 1.0  initial release
// ============================================================================
module fnd_scan_controller #(
  parameter int CLK_DIV   = 100000,  // clocks per digit slot, >= 2
  parameter int BLANK_CYC = 1000     // guard clocks per slot, < CLK_DIV
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_lzb,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_value,
  output logic        o_dp,
  output logic        o_en,
  output logic        o_frame
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] c_CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] c_BLANK   = CW'(BLANK_CYC);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } mode_e;

  mode_e          mode_q,   mode_d;
  logic [CW-1:0]  cnt_q,    cnt_d;
  logic [1:0]     idx_q,    idx_d;
  logic [15:0]    sh_val_q, sh_val_d;
  logic [3:0]     sh_dp_q,  sh_dp_d;
  logic           frame_q,  frame_d;

  logic [3:0]     w_nibble;
  logic [3:0]     w_lz_blank;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q   <= IDLE;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      sh_val_q <= 16'h0000;
      sh_dp_q  <= 4'h0;
      frame_q  <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      frame_q  <= frame_d;
    end
  end

  // Next-state logic
  always_comb begin
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    frame_d  = 1'b0;
    case (mode_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = 2'd0;
        if (i_en) begin
          // A fresh snapshot on entry, so re-enabling never shows stale data.
          mode_d   = SCAN;
          sh_val_d = i_value;
          sh_dp_d  = i_dp;
        end
      end
      SCAN: begin
        if (!i_en) begin
          mode_d = IDLE;
          cnt_d  = '0;
          idx_d  = 2'd0;
        end else if (cnt_q == c_CNT_MAX) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
          // Snapshot only at the frame boundary, so a frame never tears.
          if (idx_q == 2'd3) begin
            sh_val_d = i_value;
            sh_dp_d  = i_dp;
            frame_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // Output decode
  always_comb begin
    w_nibble = 4'h0;
    case (idx_q)
      2'd0: w_nibble = sh_val_q[3:0];
      2'd1: w_nibble = sh_val_q[7:4];
      2'd2: w_nibble = sh_val_q[11:8];
      2'd3: w_nibble = sh_val_q[15:12];
    endcase

    // A digit is blanked only when it and every more-significant digit are
    // zero. Interior zeros stay visible, and digit 0 is never blanked.
    w_lz_blank    = 4'b0000;
    w_lz_blank[3] = i_lzb & (sh_val_q[15:12] == 4'h0);
    w_lz_blank[2] = w_lz_blank[3] & (sh_val_q[11:8] == 4'h0);
    w_lz_blank[1] = w_lz_blank[2] & (sh_val_q[7:4] == 4'h0);
  end

  assign o_digitSelect = idx_q;
  assign o_value       = w_nibble;
  assign o_en          = (mode_q == SCAN) & (cnt_q >= c_BLANK) & ~w_lz_blank[idx_q];
  assign o_dp          = sh_dp_q[idx_q] & o_en;
  assign o_frame       = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fnd_scan_controller
//  Description : Scoreboard bench for fnd_scan_controller (CLK_DIV=8,
//                BLANK_CYC=2). The stimulus pushes the expected outputs of
//                each cycle. A monitor pops and compares them on the falling
//                edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fnd_scan_controller;

  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 2;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lzb;
  logic [1:0]  sel_o;
  logic [3:0]  val_o;
  logic        dp_o;
  logic        en_o;
  logic        frame_o;

  fnd_scan_controller #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_en          (en),
    .i_value       (value),
    .i_dp          (dp),
    .i_lzb         (lzb),
    .o_digitSelect (sel_o),
    .o_value       (val_o),
    .o_dp          (dp_o),
    .o_en          (en_o),
    .o_frame       (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected vector layout: {sel[1:0], value[3:0], dp, en, frame}
  logic [8:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  // Monitor: compare one expected vector per falling edge when one is queued
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      logic [8:0] a;
      e = exp_q.pop_front();
      a = {sel_o, val_o, dp_o, en_o, frame_o};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL outputs @%0t: got sel=%0d val=%h dp=%b en=%b frame=%b, expected sel=%0d val=%h dp=%b en=%b frame=%b",
                 $time, a[8:7], a[6:3], a[2], a[1], a[0], e[8:7], e[6:3], e[2], e[1], e[0]);
      end
    end
  end

  // Advance one clock, then queue the outputs expected in that cycle
  task automatic cyc(input logic [1:0] s, input logic [3:0] v,
                     input logic d, input logic e, input logic f);
    @(posedge clk);
    #1;
    exp_q.push_back({s, v, d, e, f});
  endtask

  // Cycles c_from..c_to of a digit slot.
  //   dpbit : snapshotted decimal point of the digit
  //   shown : digit not blanked by leading-zero blanking
  //   fr    : slot is entered through a 3->0 wrap
  task automatic slot_part(input logic [1:0] s, input logic [3:0] v,
                           input logic dpbit, input logic shown, input logic fr,
                           input int c_from, input int c_to);
    for (int c = c_from; c <= c_to; c++) begin
      logic act;
      act = shown && (c >= BLANK_CYC);
      cyc(s, v, dpbit & act, act, fr && (c == 0));
    end
  endtask

  task automatic slot(input logic [1:0] s, input logic [3:0] v,
                      input logic dpbit, input logic shown, input logic fr);
    slot_part(s, v, dpbit, shown, fr, 0, CLK_DIV - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; value = 16'h1234; dp = 4'b0100; lzb = 1'b0;

    // Reset held three cycles: all outputs low
    repeat (3) cyc(2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic scan of 0x1234; no frame pulse when entering from idle
    slot(2'd0, 4'h4, 1'b0, 1'b1, 1'b0);
    slot(2'd1, 4'h3, 1'b0, 1'b1, 1'b0);
    slot(2'd2, 4'h2, 1'b1, 1'b1, 1'b0);
    slot(2'd3, 4'h1, 1'b0, 1'b1, 1'b0);
    slot(2'd0, 4'h4, 1'b0, 1'b1, 1'b1);

    // Value changes mid-frame; it must not show until the wrap
    slot_part(2'd1, 4'h3, 1'b0, 1'b1, 1'b0, 0, 3);
    value = 16'h5678;
    slot_part(2'd1, 4'h3, 1'b0, 1'b1, 1'b0, 4, 7);
    slot(2'd2, 4'h2, 1'b1, 1'b1, 1'b0);
    slot(2'd3, 4'h1, 1'b0, 1'b1, 1'b0);
    slot(2'd0, 4'h8, 1'b0, 1'b1, 1'b1);
    slot(2'd1, 4'h7, 1'b0, 1'b1, 1'b0);
    slot(2'd2, 4'h6, 1'b1, 1'b1, 1'b0);

    // Leading-zero blanking; no zeros in 0x5678 so lzb has no effect yet
    lzb = 1'b1; value = 16'h0040; dp = 4'b0000;
    slot(2'd3, 4'h5, 1'b0, 1'b1, 1'b0);
    slot(2'd0, 4'h0, 1'b0, 1'b1, 1'b1);
    slot(2'd1, 4'h4, 1'b0, 1'b1, 1'b0);
    slot(2'd2, 4'h0, 1'b0, 1'b0, 1'b0);
    value = 16'h0000;
    slot(2'd3, 4'h0, 1'b0, 1'b0, 1'b0);
    slot(2'd0, 4'h0, 1'b0, 1'b1, 1'b1);
    slot(2'd1, 4'h0, 1'b0, 1'b0, 1'b0);
    slot(2'd2, 4'h0, 1'b0, 1'b0, 1'b0);
    value = 16'h1020;
    slot(2'd3, 4'h0, 1'b0, 1'b0, 1'b0);
    slot(2'd0, 4'h0, 1'b0, 1'b1, 1'b1);
    slot(2'd1, 4'h2, 1'b0, 1'b1, 1'b0);
    slot(2'd2, 4'h0, 1'b0, 1'b1, 1'b0);
    slot(2'd3, 4'h1, 1'b0, 1'b1, 1'b0);
    slot(2'd0, 4'h0, 1'b0, 1'b1, 1'b1);
    slot(2'd1, 4'h2, 1'b0, 1'b1, 1'b0);

    // Drop enable during the digit-2 slot, then re-enable with a new value
    slot_part(2'd2, 4'h0, 1'b0, 1'b1, 1'b0, 0, 2);
    en = 1'b0;
    value = 16'h9ABC; dp = 4'b0001;
    cyc(2'd0, 4'h0, 1'b0, 1'b0, 1'b0);   // idle, shadow 0x1020 retained
    cyc(2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    slot(2'd0, 4'hC, 1'b1, 1'b1, 1'b0);
    slot(2'd1, 4'hB, 1'b0, 1'b1, 1'b0);
    slot(2'd2, 4'hA, 1'b0, 1'b1, 1'b0);

    // Reset during the digit-3 slot with enable still high
    slot_part(2'd3, 4'h9, 1'b0, 1'b1, 1'b0, 0, 3);
    rst = 1'b1; value = 16'h4321; dp = 4'b1000;
    cyc(2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(2'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    slot(2'd0, 4'h1, 1'b0, 1'b1, 1'b0);
    slot(2'd1, 4'h2, 1'b0, 1'b1, 1'b0);
    slot(2'd2, 4'h3, 1'b0, 1'b1, 1'b0);
    slot(2'd3, 4'h4, 1'b1, 1'b1, 1'b0);
    slot(2'd0, 4'h1, 1'b0, 1'b1, 1'b1);

    // Let the monitor drain the last entry
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left in queue, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fnd_scan_controller.md
Name: fnd_scan_controller

Overview:
Time-multiplexed scan sequencer for the 4-digit FND display. It drives the 2-bit digit select and enable of the digit-select decoder, and the 4-bit value of the BCD-to-FND font decoder, cycling through the four digits at a programmable refresh rate. It includes frame-synchronous value snapshotting (no tearing), an anti-ghosting blank guard, and optional leading-zero blanking. It sits between the display-data producer (counters/clock logic) and the two existing decoders.

Parameters:
CLK_DIV, 100000, clocks per digit slot (100 MHz -> 1 kHz per digit); must be >= 2
BLANK_CYC, 1000, guard clocks at the start of each digit slot with o_en forced low; must be < CLK_DIV

Ports:
i_clk  input  1  system clock, all logic rising-edge
i_reset  input  1  synchronous, active-high reset
i_en  input  1  scan enable; 0 = display off/idle
i_value  input  16  four BCD/hex nibbles; [3:0]=digit 0 (least significant) .. [15:12]=digit 3
i_dp  input  4  decimal point per digit, bit k = digit k
i_lzb  input  1  leading-zero blanking enable
o_digitSelect  output  2  digit index to digit-select decoder
o_value  output  4  nibble to font decoder
o_dp  output  1  decimal point of current digit
o_en  output  1  enable to both decoders
o_frame  output  1  one-cycle pulse on each 3->0 digit wrap

Behaviour:
- State registers: mode {IDLE, SCAN}, prescaler cnt (clog2(CLK_DIV) bits), digit index idx[1:0], shadow value sh_val[15:0], shadow dp sh_dp[3:0].
- Outputs are Moore functions of the state registers (no extra pipeline stage): o_digitSelect=idx; o_value=sh_val nibble idx; o_dp=sh_dp[idx] & o_en.
- Reset (i_reset=1 at an edge): mode=IDLE, cnt=0, idx=0, sh_val=0, sh_dp=0, o_frame=0. Thus o_digitSelect=0, o_value=0, o_dp=0, o_en=0. Reset has priority over everything, including mid-scan.
- IDLE: cnt=0, idx=0, o_en=0. On an edge with i_en=1 -> SCAN, cnt=0, idx=0, sh_val<=i_value, sh_dp<=i_dp.
- SCAN, i_en=1: cnt increments each clock. The tick is cnt==CLK_DIV-1: cnt wraps to 0 and idx<=idx+1 mod 4 (00->01->10->11->00).
- On a tick with idx==3: sh_val<=i_value, sh_dp<=i_dp, and o_frame=1 for exactly that following cycle (registered pulse, coincident with idx becoming 0). Input changes at any other time are not visible until the next wrap.
- SCAN, i_en=0 at an edge: -> IDLE (cnt=0, idx=0, o_en=0 from the next cycle). The shadow is retained but reloaded on re-entry.
- o_en = (mode==SCAN) & (cnt >= BLANK_CYC) & ~lz_blank[idx].
- Leading-zero blanking, evaluated on sh_val: lz_blank[k] = i_lzb & (k!=0) & (all nibbles k..3 == 0). Digit 0 is never blanked, and an interior zero (e.g. 0x1020 digit 2) is never blanked. i_lzb is sampled live, not shadowed.
- Nibbles 0xA-0xF pass through unchanged; the font decoder owns their rendering.
- Slot timing: each digit is held exactly CLK_DIV clocks and a frame is 4*CLK_DIV clocks. o_en is low for the first BLANK_CYC clocks of each slot.

Test Plan:
(all with CLK_DIV=8, BLANK_CYC=2)
1. Assert i_reset for 3 cycles with i_en=1 -> all outputs 0 during reset; o_en stays 0.
2. Release reset with i_en=1, i_value=16'h1234, i_dp=4'b0100 -> idx sequence 0,1,2,3 with 8 clocks each; o_value 4,3,2,1; o_en low for 2 clocks then high for 6 in each slot; o_dp=1 only in enabled cycles of digit 2; o_frame pulses every 32 clocks.
3. Mid-frame (idx=1), change i_value to 16'h5678 -> digits 2 and 3 still show 2 and 1; after the wrap, o_value is 8,7,6,5.
4. i_lzb=1, i_value=16'h0040 -> digits 3 and 2 have o_en=0 for the whole slot; digit 1 shows 4 and is enabled; digit 0 shows 0 and is enabled. With i_value=16'h0000, only digit 0 is enabled. With 16'h1020, all four digits are enabled.
5. Drop i_en during the digit-2 slot -> next cycle o_en=0, o_digitSelect=0, cnt=0. Re-assert with i_value=16'h9ABC -> restarts at digit 0 showing C, with o_en low for the first 2 clocks.
6. Assert i_reset during the digit-3 slot with i_en=1 -> next edge all outputs 0 and shadow cleared. After release, scan restarts at digit 0 with a fresh snapshot and no spurious o_frame.
